ring_phase_monitor: RTL and testbench

RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

---
 rtl/ring_phase_monitor_pkg.sv | 13 +
 rtl/ring_onehot_encoder.sv | 17 +
 rtl/ring_phase_monitor.sv | 83 ++++++++
 tb/tb_ring_phase_monitor.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ring_phase_monitor_pkg.sv
// ring_phase_monitor_pkg: shared ring width, phase code, state encodings and sample classes
package ring_phase_monitor_pkg;
    localparam int RING_W = 5;
    localparam logic [2:0] PHASE_NONE = 3'd7;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;
    typedef enum logic [1:0] {CLS_ZERO, CLS_ONEHOT, CLS_MULTI} ring_cls_t;
    function automatic logic [2:0] next_phase(input logic [2:0] p);
        return (p >= 3'(RING_W - 1)) ? 3'd0 : p + 3'd1;
    endfunction
endpackage

// File: rtl/ring_onehot_encoder.sv
// ring_onehot_encoder: classifies ring taps as zero/one-hot/multi and encodes the set tap (out_a=0)
module ring_onehot_encoder
    import ring_phase_monitor_pkg::*;
(
    input  logic [RING_W-1:0] i_ring,
    output ring_cls_t         o_cls,
    output logic [2:0]        o_idx
);
    always_comb begin
        o_idx = PHASE_NONE;
        for (int b = 0; b < RING_W; b++)
            if (i_ring[b]) o_idx = 3'(RING_W - 1 - b);
        o_cls = (i_ring == '0) ? CLS_ZERO
              : ((i_ring & (i_ring - RING_W'(1))) == '0) ? CLS_ONEHOT : CLS_MULTI;
        if (o_cls != CLS_ONEHOT) o_idx = PHASE_NONE;
    end
endmodule

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: tracks ring-counter phase, locks onto clean rotation, counts revolutions, flags faults
module ring_phase_monitor
    import ring_phase_monitor_pkg::*;
#(
    parameter int REV_W = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [RING_W-1:0] ring_in,
    input  logic              err_clr,
    output logic [2:0]        phase,
    output logic              phase_valid,
    output logic              wrap_pulse,
    output logic [REV_W-1:0]  rev_count,
    output logic              err_multi,
    output logic              err_seq,
    output logic [1:0]        state
);
    ring_cls_t        w_cls;
    logic [2:0]       w_idx;
    logic             w_one;
    logic             w_multi;
    logic             w_adv;
    logic             w_wrap;
    logic             w_seq_err;
    logic [1:0]       w_state_n;
    logic [1:0]       r_state;
    logic [2:0]       r_phase;
    logic             r_valid;
    logic             r_wrap;
    logic [REV_W-1:0] r_rev;
    logic             r_err_multi;
    logic             r_err_seq;

    ring_onehot_encoder u_enc (
        .i_ring (ring_in),
        .o_cls  (w_cls),
        .o_idx  (w_idx)
    );

    assign w_one     = w_cls == CLS_ONEHOT;
    assign w_multi   = w_cls == CLS_MULTI;
    assign w_adv     = w_one && (w_idx == next_phase(r_phase));
    assign w_wrap    = (r_state == ST_LOCKED) && w_adv && (w_idx == 3'd0);
    assign w_seq_err = (r_state == ST_LOCKED) && !w_adv && !w_multi;

    // FAULT only leaves on err_clr; MULTI faults from every other state
    always_comb begin
        w_state_n = (r_state == ST_FAULT) ? (err_clr ? ST_IDLE : ST_FAULT)
                  : w_multi ? ST_FAULT
                  : (r_state == ST_LOCKED) ? (w_adv ? ST_LOCKED : ST_FAULT)
                  : !w_one ? ST_IDLE
                  : (r_state == ST_ACQUIRE && w_adv) ? ST_LOCKED : ST_ACQUIRE;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state     <= ST_IDLE;
            r_phase     <= PHASE_NONE;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_rev       <= '0;
            r_err_multi <= 1'b0;
            r_err_seq   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_phase     <= w_idx;
            r_valid     <= w_one;
            r_wrap      <= w_wrap;
            r_rev       <= r_rev + REV_W'(w_wrap);
            r_err_multi <= w_multi | (r_err_multi & ~err_clr);
            r_err_seq   <= w_seq_err | (r_err_seq & ~err_clr);
        end
    end

    assign state       = r_state;
    assign phase       = r_phase;
    assign phase_valid = r_valid;
    assign wrap_pulse  = r_wrap;
    assign rev_count   = r_rev;
    assign err_multi   = r_err_multi;
    assign err_seq     = r_err_seq;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor: directed and random checks of ring_phase_monitor against a rule-level model
module tb_ring_phase_monitor;
    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       err_clr = 1'b0;
    logic [4:0] ring_in = '0;
    logic [2:0] phase;
    logic       phase_valid;
    logic       wrap_pulse;
    logic [7:0] rev_count;
    logic       err_multi;
    logic       err_seq;
    logic [1:0] state;
    logic [2:0] phase2;
    logic       phase_valid2;
    logic       wrap_pulse2;
    logic [1:0] rev_count2;
    logic       err_multi2;
    logic       err_seq2;
    logic [1:0] state2;

    int errors = 0;
    int checks = 0;
    int m_state, m_phase, m_rev;
    bit m_valid, m_wrap, m_em, m_es;

    ring_phase_monitor #(.REV_W(8)) u_dut (
        .clk(clk), .clear(clear), .ring_in(ring_in), .err_clr(err_clr),
        .phase(phase), .phase_valid(phase_valid), .wrap_pulse(wrap_pulse),
        .rev_count(rev_count), .err_multi(err_multi), .err_seq(err_seq), .state(state)
    );

    ring_phase_monitor #(.REV_W(2)) u_dut2 (
        .clk(clk), .clear(clear), .ring_in(ring_in), .err_clr(err_clr),
        .phase(phase2), .phase_valid(phase_valid2), .wrap_pulse(wrap_pulse2),
        .rev_count(rev_count2), .err_multi(err_multi2), .err_seq(err_seq2), .state(state2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_phase = 7; m_rev = 0;
        m_valid = 0; m_wrap = 0; m_em = 0; m_es = 0;
    endtask

    task automatic model_step(input logic [4:0] r, input logic e);
        int n, p;
        bit adv, seq;
        n = 0; p = 7; seq = 0; m_wrap = 0;
        for (int i = 0; i < 5; i++) if (r[i]) begin n++; p = 4 - i; end
        if (n != 1) p = 7;
        adv = (n == 1) && (p == (m_phase + 1) % 5);
        case (m_state)
            0: m_state = (n == 0) ? 0 : (n == 1) ? 1 : 3;
            1: m_state = (n == 0) ? 0 : (n > 1) ? 3 : adv ? 2 : 1;
            2: if (adv) begin
                   m_wrap = (p == 0);
                   if (p == 0) m_rev++;
               end else begin
                   m_state = 3;
                   seq = (n < 2);
               end
            default: if (e) m_state = 0;
        endcase
        m_em = (n > 1) || (m_em && !e);
        m_es = seq || (m_es && !e);
        m_phase = p;
        m_valid = (n == 1);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, state, m_state);
        chk({tag, ".phase"}, phase, m_phase);
        chk({tag, ".phase_valid"}, phase_valid, m_valid);
        chk({tag, ".wrap_pulse"}, wrap_pulse, m_wrap);
        chk({tag, ".rev_count"}, rev_count, m_rev % 256);
        chk({tag, ".err_multi"}, err_multi, m_em);
        chk({tag, ".err_seq"}, err_seq, m_es);
        chk({tag, ".rev_count_w2"}, rev_count2, m_rev % 4);
        chk({tag, ".wrap_pulse_w2"}, wrap_pulse2, m_wrap);
    endtask

    task automatic step(input logic [4:0] r, input logic e, input string tag);
        ring_in = r;
        err_clr = e;
        @(posedge clk);
        model_step(r, e);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [4:0] r;
        logic e;
        int k;
        model_reset();
        ring_in = 5'b10000;
        #1 clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all("reset_hold");
        @(negedge clk) clear = 1'b1;
        step(5'b10000, 0, "release");
        step(5'b01000, 0, "rot1");
        step(5'b00100, 0, "rot2");
        step(5'b00010, 0, "rot3");
        step(5'b00001, 0, "rot4");
        step(5'b10000, 0, "rot_wrap");
        step(5'b01000, 0, "rot_after");
        step(5'b10100, 0, "double_token");
        step(5'b00000, 1, "double_clr");
        step(5'b10000, 0, "skip_a");
        step(5'b01000, 0, "skip_b");
        step(5'b00100, 0, "skip_c");
        step(5'b00001, 0, "skip");
        step(5'b00000, 1, "skip_clr");
        step(5'b10000, 0, "hold_a");
        step(5'b01000, 0, "hold_b");
        step(5'b00100, 0, "hold_c");
        step(5'b00100, 0, "hold");
        step(5'b00000, 1, "hold_clr");
        step(5'b10000, 0, "wrap_start");
        for (int v = 0; v < 4; v++) begin
            step(5'b01000, 0, "wrap_rev");
            step(5'b00100, 0, "wrap_rev");
            step(5'b00010, 0, "wrap_rev");
            step(5'b00001, 0, "wrap_rev");
            step(5'b10000, 0, "wrap_rev_end");
        end
        step(5'b11000, 1, "multi_beats_clr");
        step(5'b00000, 1, "multi_clr");
        step(5'b10000, 0, "midrst_a");
        step(5'b01000, 0, "midrst_b");
        step(5'b00100, 0, "midrst_c");
        #1 clear = 1'b0;
        model_reset();
        #1 check_all("async_reset");
        @(negedge clk) clear = 1'b1;
        step(5'b00010, 0, "reacquire");
        step(5'b00001, 0, "relock");
        for (int s = 0; s < 400; s++) begin
            k = int'($urandom_range(0, 9));
            if (k < 7) r = (m_phase != 7) ? 5'b10000 >> ((m_phase + 1) % 5)
                                          : 5'b10000 >> $urandom_range(0, 4);
            else if (k == 7) r = 5'b00000;
            else if (k == 8) r = 5'($urandom);
            else r = (m_phase != 7) ? 5'b10000 >> m_phase : 5'b00000;
            e = (m_state == 3) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 15) == 0);
            step(r, e, "random");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
